// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data-memory responder: RISC-V load/store funct3 codes
// and the responder FSM state encoding.
package data_memory_responder_pkg;

  localparam logic [2:0] MEM_BYTE   = 3'b000;
  localparam logic [2:0] MEM_HALF   = 3'b001;
  localparam logic [2:0] MEM_WORD   = 3'b010;
  localparam logic [2:0] MEM_BYTE_U = 3'b100;
  localparam logic [2:0] MEM_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/data_memory_responder_lane.sv
// memory_lane_aligner: combinational byte-lane steering for RISC-V sub-word accesses.
// Low address bits are masked to natural alignment; misalign reports what was masked.
module memory_lane_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] write_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_half = addr_lo[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    rd_byte = read_word[7:0];
    case (addr_lo)
      2'd1:    rd_byte = read_word[15:8];
      2'd2:    rd_byte = read_word[23:16];
      2'd3:    rd_byte = read_word[31:24];
      default: rd_byte = read_word[7:0];
    endcase
  end

  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0;
    load_data  = 32'h0;
    misalign   = 1'b0;
    case (funct3)
      MEM_BYTE, MEM_BYTE_U: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{write_data[7:0]}};
        load_data  = {{24{rd_byte[7] & ~funct3[2]}}, rd_byte};
      end
      MEM_HALF, MEM_HALF_U: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
        load_data  = {{16{rd_half[15] & ~funct3[2]}}, rd_half};
        misalign   = addr_lo[0];
      end
      MEM_WORD: begin
        byte_en    = 4'b1111;
        store_word = write_data;
        load_data  = read_word;
        misalign   = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, word RAM.
// Define RVSIMPLE_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of masking.
//
// state   | meaning
// ST_IDLE | ready for a request
// ST_WAIT | counting down wait states for the latched request
// ST_RESP | response held until rsp_ready
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          WAIT_CYCLES  = 2,
  parameter logic [31:0] BASE_ADDRESS = 32'h80000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_read_data,
  output logic        rsp_error
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH_WORDS);
  localparam logic [29:0] BASE_W    = BASE_ADDRESS[31:2];
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef RVSIMPLE_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  state_t      state;
  logic [3:0]  count;
  logic        lat_write;
  logic [31:0] lat_address;
  logic [31:0] lat_write_data;
  logic [2:0]  lat_funct3;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, do_access, fault, bad_funct3, in_range, misalign;
  logic        acc_write;
  logic [31:0] acc_address, acc_write_data, read_word, store_word, load_data;
  logic [2:0]  acc_funct3;
  logic [29:0] word_off;
  logic [IDX_W-1:0] index;
  logic [3:0]  byte_en;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge, before the latch holds it.
  assign acc_write      = (state == ST_IDLE) ? req_write      : lat_write;
  assign acc_address    = (state == ST_IDLE) ? req_address    : lat_address;
  assign acc_write_data = (state == ST_IDLE) ? req_write_data : lat_write_data;
  assign acc_funct3     = (state == ST_IDLE) ? req_funct3     : lat_funct3;

  assign do_access = ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state == ST_WAIT) && (count == 4'd1));

  // Compared at word granularity so an address below the base never wraps into range.
  assign word_off  = acc_address[31:2] - BASE_W;
  assign in_range  = (acc_address[31:2] >= BASE_W) && (word_off < DEPTH_W);
  assign index     = word_off[IDX_W-1:0];
  assign read_word = mem[index];

  always_comb begin
    case (acc_funct3)
      MEM_BYTE, MEM_HALF, MEM_WORD: bad_funct3 = 1'b0;
      MEM_BYTE_U, MEM_HALF_U:       bad_funct3 = acc_write;
      default:                      bad_funct3 = 1'b1;
    endcase
  end

  assign fault = !in_range || bad_funct3 || (MISALIGN_TRAP && misalign);

  memory_lane_aligner u_lane (
    .funct3     (acc_funct3),
    .addr_lo    (acc_address[1:0]),
    .write_data (acc_write_data),
    .read_word  (read_word),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      count         <= 4'd0;
      rsp_valid     <= 1'b0;
      rsp_read_data <= 32'h0;
      rsp_error     <= 1'b0;
    end else begin
      if (do_access) begin
        rsp_error     <= fault;
        rsp_read_data <= (fault || acc_write) ? 32'h0 : load_data;
        if (!fault && acc_write) begin
          for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[index][8*i +: 8] <= store_word[8*i +: 8];
          end
        end
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write      <= req_write;
            lat_address    <= req_address;
            lat_write_data <= req_write_data;
            lat_funct3     <= req_funct3;
            count          <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed vector table, hold/reset sequences and
// randomized traffic against a byte-array reference model (honours RVSIMPLE_MISALIGN_TRAP_EN).
module tb_data_memory_responder;

  localparam int          WAITC = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h80000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_address = 32'h0, req_write_data = 32'h0;
  logic [2:0]  req_funct3 = 3'b010;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [31:0] rsp_read_data;

  int total = 0;
  int bad   = 0;

  data_memory_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .req_funct3     (req_funct3),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_read_data  (rsp_read_data),
    .rsp_error      (rsp_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] mb [64];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, logic [2:0] f,
                              logic [31:0] ed, logic ee);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.f = f; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  // Reference model over the first 64 bytes of RAM, written from the access rules.
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, output logic [31:0] ed, output logic ee);
    int unsigned size, ea, off;
    size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    ee = 1'b0;
    ed = 32'h0;
    if (f == 3'd3 || f == 3'd6 || f == 3'd7 || (w && f[2])) ee = 1'b1;
    if (a < BASE || a >= BASE + 4 * DEPTH) ee = 1'b1;
`ifdef RVSIMPLE_MISALIGN_TRAP_EN
    if (a % size != 0) ee = 1'b1;
`endif
    if (!ee) begin
      ea  = a - (a % size);
      off = ea - BASE;
      if (w) begin
        for (int i = 0; i < int'(size); i++) mb[off + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < int'(size); i++) ed = ed | ({24'h0, mb[off + i]} << (8 * i));
        if (!f[2] && size == 1) ed = {{24{ed[7]}}, ed[7:0]};
        if (!f[2] && size == 2) ed = {{16{ed[15]}}, ed[15:0]};
      end
    end
  endfunction

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input int hold,
                     output logic [31:0] rd, output logic er);
    int n;
    int lat;
    @(negedge clock);
    req_write = w; req_address = a; req_write_data = d; req_funct3 = f; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_wait", 32'(n < 20), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clock);
      #1 lat++;
    end
    check("latency", lat, WAITC + 1);
    rd = rsp_read_data;
    er = rsp_error;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_read_data, rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    check("ready_after_rsp", 32'(req_ready), 32'd1);
    check("valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, ed, a;
    logic        er, ee, w, seen;
    logic [2:0]  f;

    vecs.push_back(mk(1, 32'h80000010, 32'hDEADBEEF, 3'd2, 32'h0, 0));
    vecs.push_back(mk(0, 32'h80000010, 32'h0,        3'd2, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h80000010, 32'h11223344, 3'd2, 32'h0, 0));
    vecs.push_back(mk(1, 32'h80000013, 32'hABCDEF80, 3'd0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h80000013, 32'h0,        3'd0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 32'h80000013, 32'h0,        3'd4, 32'h00000080, 0));
    vecs.push_back(mk(0, 32'h80000010, 32'h0,        3'd2, 32'h80223344, 0));
    vecs.push_back(mk(0, 32'h80000012, 32'h0,        3'd1, 32'hFFFF8022, 0));
    vecs.push_back(mk(0, 32'h80000012, 32'h0,        3'd5, 32'h00008022, 0));
`ifdef RVSIMPLE_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 32'h80000011, 32'h0,        3'd1, 32'h0, 1));
    vecs.push_back(mk(0, 32'h80000012, 32'h0,        3'd2, 32'h0, 1));
`else
    vecs.push_back(mk(0, 32'h80000011, 32'h0,        3'd1, 32'h00003344, 0));
    vecs.push_back(mk(0, 32'h80000012, 32'h0,        3'd2, 32'h80223344, 0));
`endif
    vecs.push_back(mk(1, 32'h80000FFC, 32'hCAFEF00D, 3'd2, 32'h0, 0));
    vecs.push_back(mk(0, 32'h7FFFFFFC, 32'h0,        3'd2, 32'h0, 1));
    vecs.push_back(mk(0, 32'h80001000, 32'h0,        3'd2, 32'h0, 1));
    vecs.push_back(mk(1, 32'h80001000, 32'h0,        3'd2, 32'h0, 1));
    vecs.push_back(mk(1, 32'h80000FFC, 32'h0,        3'd4, 32'h0, 1));
    vecs.push_back(mk(0, 32'h80000FFC, 32'h0,        3'd3, 32'h0, 1));
    vecs.push_back(mk(1, 32'h80000FFC, 32'h0,        3'd6, 32'h0, 1));
    vecs.push_back(mk(0, 32'h80000FFC, 32'h0,        3'd2, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 32'h00000010, 32'h0,        3'd2, 32'h0, 1));
    vecs.push_back(mk(1, 32'h80000014, 32'h0,        3'd2, 32'h0, 0));
    vecs.push_back(mk(1, 32'h80000016, 32'h1234BEEF, 3'd1, 32'h0, 0));
    vecs.push_back(mk(0, 32'h80000014, 32'h0,        3'd2, 32'hBEEF0000, 0));
    vecs.push_back(mk(1, 32'h80000020, 32'h0,        3'd2, 32'h0, 0));

    repeat (3) @(posedge clock);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_read_data, 32'h0);
    check("reset_rsp_error", 32'(rsp_error), 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].f, 0, rd, er);
      check($sformatf("vec%0d_data", i), rd, vecs[i].ed);
      check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].ee));
    end

    // Response held under back-pressure.
    txn(1'b0, 32'h80000FFC, 32'h0, 3'd2, 5, rd, er);
    check("hold_final_data", rd, 32'hCAFEF00D);

    // Reset one cycle after accepting a store: the store must be lost.
    @(negedge clock);
    req_write = 1'b1; req_address = 32'h80000020; req_write_data = 32'h12345678;
    req_funct3 = 3'd2; req_valid = 1'b1;
    check("rst_seq_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1 if (rsp_valid) seen = 1'b1;
    end
    check("rst_seq_no_rsp", 32'(seen), 32'd0);
    check("rst_seq_ready_after", 32'(req_ready), 32'd1);
    txn(1'b0, 32'h80000020, 32'h0, 3'd2, 0, rd, er);
    check("rst_seq_store_dropped", rd, 32'h0);

    // Randomized traffic over the first 16 words.
    for (int i = 0; i < 16; i++) begin
      a = BASE + 32'(4 * i);
      model(1'b1, a, $urandom, 3'd2, ed, ee);
      txn(1'b1, a, {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]}, 3'd2, 0, rd, er);
      check("rand_init_error", 32'(er), 32'd0);
    end
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 256));
        1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      rd = $urandom;
      model(w, a, rd, f, ed, ee);
      txn(w, a, rd, f, 0, rd, er);
      check($sformatf("rand%0d_data a=%h f=%0d w=%0d", i, a, f, w), rd, ed);
      check($sformatf("rand%0d_error", i), 32'(er), 32'(ee));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
